// File: rtl/vlc_pkg.sv
// ----------------------------------------------------------------------------
// vlc_pkg
// Shared constants and types for the VLC link: encoded and decoded frame
// widths, the default receiver oversampling ratio and the receiver FSM state
// type.
// ----------------------------------------------------------------------------
package vlc_pkg;

    localparam int FRAME_W = 36;  // LDPC-encoded frame width
    localparam int DATA_W  = 27;  // payload width before encoding
    localparam int VLC_OSR = 8;   // default main_clk cycles per line bit

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/rx_bit_sampler.sv
// ----------------------------------------------------------------------------
// rx_bit_sampler
// Front end of the VLC receiver. It synchronises the raw photodetector line,
// detects the idle-to-start rising edge, runs the bit-phase counter and issues
// one decision strobe per bit period together with the decided bit value.
//
// Optional feature: VLC_RX_MAJORITY_EN. When it is defined, each bit is a
// 2-of-3 vote of the samples at centre-1, centre and centre+1, and the
// strobe fires at centre+1. When it is not defined, a single sample is taken
// at the centre.
//
// Ports:
//   main_clk   in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx_in      in   asynchronous serial line, idle low
//   phase_clr  in   restart the bit phase (cycle t0)
//   start_edge out  synchronised line rose this cycle
//   bit_strobe out  bit decision point of the current bit period
//   bit_val    out  decided bit value, valid with bit_strobe
// ----------------------------------------------------------------------------
module rx_bit_sampler
    import vlc_pkg::*;
#(
    parameter int OSR = VLC_OSR
) (
    input  logic main_clk,
    input  logic rst_n,
    input  logic rx_in,
    input  logic phase_clr,
    output logic start_edge,
    output logic bit_strobe,
    output logic bit_val
);

    localparam int PW = $clog2(OSR);

    logic          sync1_reg;
    logic          rx_s_reg;
    logic          rx_s_d_reg;
    logic [PW-1:0] phase_reg;

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= 1'b0;
            rx_s_reg   <= 1'b0;
            rx_s_d_reg <= 1'b0;
        end else begin
            sync1_reg  <= rx_in;
            rx_s_reg   <= sync1_reg;
            rx_s_d_reg <= rx_s_reg;
        end
    end

    assign start_edge = rx_s_reg & ~rx_s_d_reg;

    // Phase is 0 in the cycle after t0, so the bit centre of bit k lands on
    // phase OSR/2-1, i.e. cycle t0 + OSR/2 + k*OSR.
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
        end else if (phase_clr || phase_reg == PW'(OSR - 1)) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_reg + 1'b1;
        end
    end

`ifdef VLC_RX_MAJORITY_EN
    localparam logic [PW-1:0] PH_DEC = PW'(OSR / 2);

    logic early_reg;
    logic mid_reg;

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            early_reg <= 1'b0;
            mid_reg   <= 1'b0;
        end else begin
            if (phase_reg == PH_DEC - 2'd2) early_reg <= rx_s_reg;
            if (phase_reg == PH_DEC - 2'd1) mid_reg   <= rx_s_reg;
        end
    end

    // The third vote is the live centre+1 sample, so the decision needs no
    // extra register stage.
    assign bit_strobe = (phase_reg == PH_DEC);
    assign bit_val    = (early_reg & mid_reg) | (early_reg & rx_s_reg) |
                        (mid_reg & rx_s_reg);
`else
    localparam logic [PW-1:0] PH_DEC = PW'(OSR / 2 - 1);

    assign bit_strobe = (phase_reg == PH_DEC);
    assign bit_val    = rx_s_reg;
`endif

endmodule

// File: rtl/vlc_frame_receiver.sv
// ----------------------------------------------------------------------------
// vlc_frame_receiver
// Receives one start bit, FRAME_W data bits (MSB first) and one stop bit from
// the oversampled optical line, and hands good frames to the LDPC decoder.
// Frames whose stop bit is 1 raise frame_err and are dropped.
//
// Optional feature: VLC_RX_MAJORITY_EN (handled in rx_bit_sampler) moves each
// decision and the output pulse one cycle later and adds a 2-of-3 vote.
//
// Ports:
//   main_clk    in   system clock
//   rst_n       in   asynchronous active-low reset
//   rx_in       in   asynchronous serial line, idle low
//   frame_data  out  last good frame, bit FRAME_W-1 = first data bit
//   frame_valid out  one-cycle pulse, frame_data updated in the same cycle
//   frame_err   out  one-cycle pulse on a bad stop bit
//   busy        out  receiver is inside a frame (including the pulse cycle)
// ----------------------------------------------------------------------------
module vlc_frame_receiver
    import vlc_pkg::*;
#(
    parameter int OSR = VLC_OSR
) (
    input  logic               main_clk,
    input  logic               rst_n,
    input  logic               rx_in,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_valid,
    output logic               frame_err,
    output logic               busy
);

    rx_state_t          state_reg;
    rx_state_t          state_next;
    logic [5:0]         bit_cnt_reg;
    logic [FRAME_W-1:0] shift_reg;
    logic [FRAME_W-1:0] frame_data_reg;
    logic               valid_reg;
    logic               err_reg;

    logic phase_clr;
    logic start_edge;
    logic bit_strobe;
    logic bit_val;
    logic cnt_clr;
    logic shift_en;
    logic load_frame;
    logic stop_bad;

    rx_bit_sampler #(
        .OSR(OSR)
    ) u_sampler (
        .main_clk  (main_clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .phase_clr (phase_clr),
        .start_edge(start_edge),
        .bit_strobe(bit_strobe),
        .bit_val   (bit_val)
    );

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_clr  = 1'b0;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        load_frame = 1'b0;
        stop_bad   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    phase_clr  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_strobe) begin
                    if (bit_val) begin
                        cnt_clr    = 1'b1;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;  // false start, silent
                    end
                end
            end
            DATA: begin
                if (bit_strobe) begin
                    shift_en = 1'b1;
                    if (bit_cnt_reg == 6'(FRAME_W - 1)) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_strobe) begin
                    load_frame = ~bit_val;
                    stop_bad   = bit_val;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            frame_data_reg <= '0;
            valid_reg      <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            if (cnt_clr) begin
                bit_cnt_reg <= '0;
            end else if (shift_en) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {shift_reg[FRAME_W-2:0], bit_val};
            end
            if (load_frame) begin
                frame_data_reg <= shift_reg;
            end
            valid_reg <= load_frame;
            err_reg   <= stop_bad;
        end
    end

    assign frame_data  = frame_data_reg;
    assign frame_valid = valid_reg;
    assign frame_err   = err_reg;
    // The FSM is already back in IDLE during the pulse cycle; the pulse terms
    // keep busy asserted through it.
    assign busy        = (state_reg != IDLE) | valid_reg | err_reg;

endmodule
